// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - round-robin command sequencer driving one mod-10 up/down counter
// Optional macro CNT_CHECK_EN adds err/err_id and a reference count model.
module counter_sequencer #(
   parameter int LEN_W = 4,
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_mode,
   input  logic             req0_step,
   input  logic             req0_clr,
   input  logic [LEN_W-1:0] req0_len,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_mode,
   input  logic             req1_step,
   input  logic             req1_clr,
   input  logic [LEN_W-1:0] req1_len,
   output logic             Mode,
   output logic             Step,
   output logic             En,
   output logic             CntRst,
   input  logic [CNT_W-1:0] Cnt,
   output logic             done,
   output logic             done_id,
   output logic [CNT_W-1:0] done_cnt,
   output logic             wrap,
`ifdef CNT_CHECK_EN
   output logic             err,
   output logic             err_id,
`endif
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_RUN,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t           r_state;
   logic             r_last_grant;
   logic             r_clr;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_rem;
   logic             r_id;
   logic [CNT_W-1:0] r_prev;

   logic             w_gnt_vld;
   logic             w_gnt_id;
   logic             w_acc;
   logic             w_mode;
   logic             w_step;
   logic             w_clr;
   logic [LEN_W-1:0] w_len;
   logic             w_wrap_hit;

   // With both requesters valid, the one not granted last time wins.
   always_comb begin
      w_gnt_vld = req0_valid | req1_valid;
      if (req0_valid && req1_valid) w_gnt_id = ~r_last_grant;
      else                          w_gnt_id = req1_valid;
   end

   assign w_acc      = (r_state == S_IDLE) && w_gnt_vld;
   assign req0_ready = w_acc && !w_gnt_id;
   assign req1_ready = w_acc &&  w_gnt_id;

   assign w_mode = w_gnt_id ? req1_mode : req0_mode;
   assign w_step = w_gnt_id ? req1_step : req0_step;
   assign w_clr  = w_gnt_id ? req1_clr  : req0_clr;
   assign w_len  = w_gnt_id ? req1_len  : req0_len;

   assign w_wrap_hit = (Mode && (Cnt < r_prev)) || (!Mode && (Cnt > r_prev));

`ifdef CNT_CHECK_EN
   logic [CNT_W-1:0] r_exp;

   function automatic logic [CNT_W-1:0] f_next(input logic [CNT_W-1:0] v,
                                               input logic up, input logic s3);
      int iv;
      int d;
      iv = int'(v);
      d  = s3 ? 3 : 1;
      if (up) iv = (iv + d >= 10) ? iv + d - 10 : iv + d;
      else    iv = (iv >= d) ? iv - d : iv + 10 - d;
      return CNT_W'(iv);
   endfunction
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_clr        <= 1'b0;
         r_len        <= '0;
         r_rem        <= '0;
         r_id         <= 1'b0;
         r_prev       <= '0;
         Mode         <= 1'b0;
         Step         <= 1'b0;
         En           <= 1'b0;
         CntRst       <= 1'b0;
         done         <= 1'b0;
         done_id      <= 1'b0;
         done_cnt     <= '0;
         wrap         <= 1'b0;
         busy         <= 1'b0;
`ifdef CNT_CHECK_EN
         r_exp        <= '0;
         err          <= 1'b0;
         err_id       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_state      <= S_SETUP;
                  busy         <= 1'b1;
                  Mode         <= w_mode;
                  Step         <= w_step;
                  CntRst       <= w_clr;
                  r_clr        <= w_clr;
                  r_len        <= w_len;
                  r_id         <= w_gnt_id;
                  r_last_grant <= w_gnt_id;
               end
            end
            S_SETUP: begin
               CntRst <= 1'b0;
               wrap   <= 1'b0;
               r_prev <= Cnt;
               r_rem  <= r_len;
`ifdef CNT_CHECK_EN
               r_exp  <= r_clr ? '0 : Cnt;
`endif
               if (!r_clr && (r_len != '0)) begin
                  En      <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_SETTLE;
               end
            end
            S_RUN: begin
               if (w_wrap_hit) wrap <= 1'b1;
               r_prev <= Cnt;
`ifdef CNT_CHECK_EN
               r_exp  <= f_next(r_exp, Mode, Step);
`endif
               if (r_rem == LEN_W'(1)) begin
                  En      <= 1'b0;
                  r_state <= S_SETTLE;
               end else begin
                  r_rem <= r_rem - LEN_W'(1);
               end
            end
            S_SETTLE: begin
               if (w_wrap_hit) wrap <= 1'b1;
               r_prev   <= Cnt;
               done     <= 1'b1;
               done_id  <= r_id;
               done_cnt <= Cnt;
               r_state  <= S_DONE;
`ifdef CNT_CHECK_EN
               // Only the first mismatching command is blamed.
               if ((Cnt != r_exp) && !err) begin
                  err    <= 1'b1;
                  err_id <= r_id;
               end
`endif
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
